// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: lane-shifts stores, extends loads, and stalls until the data memory handshake completes.
// Optional `LSU_TIMEOUT_EN` aborts a BUSY access after TIMEOUT_CYCLES cycles with no dmem_ready.
module lsu_mem_stage #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic [3:0]        mem_write,
  input  logic [1:0]        read_size,
  input  logic              read_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              access_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              timeout;

  function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off);
    logic [31:0] w;
    logic [15:0] h;
    w = rdata >> {off, 3'b000};
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    return sgn ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return rdata;
    endcase
  endfunction

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == BUSY) && !dmem_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY) cnt_d = '0;
    else if (!dmem_ready && !timeout) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  logic       access, is_half, is_word, bad;
  logic [3:0] mask;

  always_comb begin
    access  = req_valid & (mem_read | (|mem_write));
    is_half = mem_read ? (read_size == 2'd1) : (mem_write == 4'b0011);
    is_word = mem_read ? (read_size == 2'd2) : (mem_write == 4'b1111);
    bad     = (mem_read & (|mem_write))
            | (mem_read & (read_size == 2'd3))
            | (!mem_read && (|mem_write) && !(mem_write inside {4'b0001, 4'b0011, 4'b1111}))
            | (is_half & addr[0])
            | (is_word & (|addr[1:0]));
    case (read_size)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    if (!mem_read) mask = mem_write;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    stall       = 1'b0;
    access_err  = 1'b0;
    load_valid  = 1'b0;
    dmem_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (bad) begin
            access_err = 1'b1;
          end else begin
            stall     = 1'b1;
            we_d      = !mem_read;
            be_d      = mask << addr[1:0];
            addr_d    = {addr[ADDR_W-1:2], 2'b00};
            wdata_d   = store_data << {addr[1:0], 3'b000};
            is_load_d = mem_read;
            size_d    = read_size;
            sgn_d     = read_signed;
            off_d     = addr[1:0];
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (timeout) begin
          access_err = 1'b1;
          state_d    = IDLE;
        end else begin
          dmem_req = 1'b1;
          stall    = 1'b1;
          if (dmem_ready) begin
            if (is_load_q) load_data_d = extend_load(dmem_rdata, size_q, sgn_q, off_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // req_valid here still belongs to the retiring instruction.
        load_valid = is_load_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      is_load_q   <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      off_q       <= 2'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = load_data_q;

endmodule
